piso_tx: RTL and testbench

- Parallel-in, serial-out frame transmitter: the sending end of the team's serial link, feeding the deserialising receiver that fills the load/clear data registers.
- Captures a w-bit word on a load strobe and shifts it out as a framed serial stream: start bit, w data bits, stop bit.
- Each bit is held for DIV clocks; the idle line level is 1.
- Sits between a parallel register bank and the serial pin.

---
 rtl/piso_tx_pkg.sv | 16 +
 rtl/piso_tx_bit_tick.sv | 31 +++
 rtl/piso_tx.sv | 112 +++++++++++
 tb/tb_piso_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/piso_tx_pkg.sv
// Shared types and sizing helpers for the piso_tx serial frame transmitter.
package piso_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Counter width that never collapses to zero bits, so DIV=1 or w=1 still build.
  function automatic int unsigned cntw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_tx_bit_tick.sv
// Bit-period timer: counts 0..DIV-1 while enabled and flags the terminal count.
module piso_tx_bit_tick
  import piso_tx_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rstb,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned TW = cntw(DIV);
  localparam logic [TW-1:0] TERM = TW'(DIV - 1);

  logic [TW-1:0] cnt;

  assign tick_c = en && (cnt == TERM);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick_c ? '0 : cnt + TW'(1);
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: start bit, w data bits, stop bit, DIV clocks per bit.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int unsigned w    = 8,
  parameter int unsigned DIV  = 4,
  parameter int unsigned MSBF = 0
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic [w-1:0] d,
  input  logic         ld,
  input  logic         clr,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int unsigned IW   = cntw(w);
  localparam logic [IW-1:0] LAST = IW'(w - 1);
  localparam int unsigned OB   = (MSBF != 0) ? w - 1 : 0;

  state_t        state, state_n;
  logic [w-1:0]  sr, sr_n;
  logic [IW-1:0] idx, idx_n;
  logic          tx_n, busy_n, done_n;
  logic          tick_c;

  piso_tx_bit_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rstb   (rstb),
    .clr    (clr),
    .en     (state != IDLE),
    .tick_c (tick_c)
  );

  // Next-state and next-output logic; the head of sr is always the next data bit.
  always_comb begin
    state_n = state;
    sr_n    = sr;
    idx_n   = idx;
    tx_n    = tx;
    busy_n  = busy;
    done_n  = 1'b0;
    if (clr) begin
      state_n = IDLE;
      tx_n    = 1'b1;
      busy_n  = 1'b0;
      idx_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (ld) begin
            state_n = START;
            sr_n    = d;
            tx_n    = 1'b0;
            busy_n  = 1'b1;
          end
        end
        START: begin
          if (tick_c) begin
            state_n = DATA;
            tx_n    = sr[OB];
            sr_n    = (MSBF != 0) ? (sr << 1) : (sr >> 1);
            idx_n   = '0;
          end
        end
        DATA: begin
          if (tick_c) begin
            if (idx == LAST) begin
              state_n = STOP;
              tx_n    = 1'b1;
              idx_n   = '0;
            end else begin
              tx_n  = sr[OB];
              sr_n  = (MSBF != 0) ? (sr << 1) : (sr >> 1);
              idx_n = idx + IW'(1);
            end
          end
        end
        STOP: begin
          if (tick_c) begin
            state_n = IDLE;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      sr    <= '0;
      idx   <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      idx   <= idx_n;
      tx    <= tx_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: three configurations (LSB/DIV4, MSB/DIV4, LSB/DIV1) against a frame-timing model.
module tb_piso_tx;

  localparam int W = 8;
  localparam int DIVS [3] = '{4, 4, 1};
  localparam int MSBS [3] = '{0, 1, 0};

  logic         clk = 1'b0;
  logic         rstb = 1'b1;
  logic [W-1:0] d = '0;
  logic         ld = 1'b0;
  logic         clr = 1'b0;
  logic [2:0]   txv, busyv, donev;

  int n_chk = 0;
  int n_err = 0;

  // Model: per configuration, whether a frame is running, clocks since acceptance, word, done.
  bit           m_act [3];
  int           m_el  [3];
  logic [W-1:0] m_wd  [3];
  bit           m_dn  [3];

  typedef struct {
    int           dut;
    logic [W-1:0] d;
    logic [9:0]   frame;  // transmission order, frame[9] goes first
    int           len;
  } vec_t;
  vec_t tab [5];

  piso_tx #(.w(8), .DIV(4), .MSBF(0)) u_lsb (
    .clk(clk), .rstb(rstb), .d(d), .ld(ld), .clr(clr),
    .tx(txv[0]), .busy(busyv[0]), .done(donev[0]));
  piso_tx #(.w(8), .DIV(4), .MSBF(1)) u_msb (
    .clk(clk), .rstb(rstb), .d(d), .ld(ld), .clr(clr),
    .tx(txv[1]), .busy(busyv[1]), .done(donev[1]));
  piso_tx #(.w(8), .DIV(1), .MSBF(0)) u_div1 (
    .clk(clk), .rstb(rstb), .d(d), .ld(ld), .clr(clr),
    .tx(txv[2]), .busy(busyv[2]), .done(donev[2]));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s got %b want %b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s got %0d want %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic exp_tx(input int i);
    int k;
    if (!m_act[i]) return 1'b1;
    k = m_el[i] / DIVS[i];
    if (k == 0) return 1'b0;
    if (k > W) return 1'b1;
    return (MSBS[i] != 0) ? m_wd[i][W-k] : m_wd[i][k-1];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 1'b0;
      m_el[i]  = 0;
      m_dn[i]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (!rstb) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        m_act[i] = 1'b0;
        m_el[i]  = 0;
        m_dn[i]  = 1'b0;
      end else if (m_act[i]) begin
        m_el[i]++;
        m_dn[i] = 1'b0;
        if (m_el[i] == (W + 2) * DIVS[i]) begin
          m_act[i] = 1'b0;
          m_dn[i]  = 1'b1;
        end
      end else begin
        m_dn[i] = 1'b0;
        if (ld) begin
          m_act[i] = 1'b1;
          m_el[i]  = 0;
          m_wd[i]  = d;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tx%0d", i), txv[i], exp_tx(i));
      chk($sformatf("busy%0d", i), busyv[i], m_act[i]);
      chk($sformatf("done%0d", i), donev[i], m_dn[i]);
    end
  endtask

  // One clock: the model sees the same pre-edge inputs, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int n;
    int busy_cnt;
    int dcnt;
    int dv;

    tab[0] = '{0, 8'hA5, 10'b0_10100101_1, 40};
    tab[1] = '{1, 8'hA5, 10'b0_10100101_1, 40};
    tab[2] = '{1, 8'h3C, 10'b0_00111100_1, 40};
    tab[3] = '{0, 8'h3C, 10'b0_00111100_1, 40};
    tab[4] = '{2, 8'h81, 10'b0_10000001_1, 10};

    // Reset, then a long idle stretch.
    #1 rstb = 1'b0;
    #1;
    model_reset();
    compare_all();
    #19 rstb = 1'b1;
    repeat (100) step();

    // Table-driven single frames.
    for (int e = 0; e < 5; e++) begin
      dv = DIVS[tab[e].dut];
      d  = tab[e].d;
      ld = 1'b1;
      step();
      ld = 1'b0;
      d  = W'($urandom);
      busy_cnt = 0;
      for (int c = 0; c < tab[e].len; c++) begin
        chk($sformatf("vec%0d_bit%0d", e, c / dv), txv[tab[e].dut], tab[e].frame[9 - c / dv]);
        if (busyv[tab[e].dut]) busy_cnt++;
        step();
      end
      chk($sformatf("vec%0d_done", e), donev[tab[e].dut], 1'b1);
      chk_int($sformatf("vec%0d_busy_len", e), busy_cnt, tab[e].len);
      repeat (45 - tab[e].len) step();
    end

    // Back-to-back: load in the done cycle, then a load attempt mid-frame.
    d = 8'hA5; ld = 1'b1;
    step();
    ld = 1'b0;
    n = 0;
    while (!donev[0] && n < 60) begin
      step();
      n++;
    end
    chk("b2b_done", donev[0], 1'b1);
    chk("b2b_done_busy", busyv[0], 1'b0);
    d = 8'h3C; ld = 1'b1;
    step();
    ld = 1'b0;
    chk("b2b_start_tx", txv[0], 1'b0);
    chk("b2b_start_busy", busyv[0], 1'b1);
    chk("b2b_done_clear", donev[0], 1'b0);
    repeat (10) step();
    d = 8'hFF; ld = 1'b1;
    step();
    ld = 1'b0;
    repeat (40) step();

    // Abort mid-frame: no done may follow.
    d = 8'hA5; ld = 1'b1;
    step();
    ld = 1'b0;
    repeat (14) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("abort_tx", txv[0], 1'b1);
    chk("abort_busy", busyv[0], 1'b0);
    dcnt = 0;
    repeat (50) begin
      step();
      if (donev[0]) dcnt++;
    end
    chk_int("abort_no_done", dcnt, 0);

    // clr wins over ld in the same cycle.
    clr = 1'b1; ld = 1'b1; d = 8'hA5;
    step();
    clr = 1'b0; ld = 1'b0;
    chk("clr_ld_busy", busyv[0], 1'b0);
    chk("clr_ld_tx", txv[0], 1'b1);
    repeat (5) step();

    // Asynchronous reset pulse between edges while in DATA.
    d = 8'h00; ld = 1'b1;
    step();
    ld = 1'b0;
    repeat (9) step();
    chk("async_pre_busy", busyv[0], 1'b1);
    #1 rstb = 1'b0;
    #1;
    model_reset();
    chk("async_tx", txv[0], 1'b1);
    chk("async_busy", busyv[0], 1'b0);
    compare_all();
    rstb = 1'b1;
    repeat (50) step();

    // Random traffic against the model.
    repeat (3000) begin
      ld  = ($urandom_range(7) == 0);
      clr = ($urandom_range(63) == 0);
      d   = W'($urandom);
      step();
    end
    ld = 1'b0; clr = 1'b0;
    repeat (45) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
